// File: rtl/score_display.sv
// Seven-segment score readout for the VGA pixel path: sequential binary-to-BCD conversion,
// frame-synchronous digit commit, registered hit test. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module score_display #(
    parameter int          SCORE_W = 14,
    parameter int          NDIG    = 4,
    parameter int          X0      = 565,
    parameter int          Y0      = 20,
    parameter int          DIG_W   = 10,
    parameter int          DIG_H   = 20,
    parameter int          PITCH   = 15,
    parameter int          SEG_T   = 2,
    parameter logic [11:0] COLOR   = 12'hFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic               busy,
    output logic               is_score,
    output logic [11:0]        score_rgb
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int SEG_M = (DIG_H - SEG_T) / 2;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAX_SHOWN = pow10(NDIG) - 1;

    // Segment bits ordered {a,b,c,d,e,f,g}; nibbles 10-15 stay dark.
    function automatic logic [6:0] seg_map(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state, state_nx;
    logic [SCORE_W-1:0] shift_q, last_score;
    logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_step, result, pending, shown;
    logic [CNT_W-1:0]   cnt;
    logic               pending_valid, sat_q, start, done, hit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (score != last_score) begin
                start    = 1'b1;
                state_nx = CONV;
            end
            CONV: if (cnt == CNT_W'(SCORE_W - 1)) begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next score bit.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NDIG; i++)
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        bcd_step = (bcd_adj << 1) | BCD_W'(shift_q[SCORE_W-1]);
        result   = sat_q ? {NDIG{4'h9}} : bcd_step;
    end

    assign busy = (state == CONV);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            shift_q       <= '0;
            last_score    <= '0;
            bcd_q         <= '0;
            cnt           <= '0;
            sat_q         <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            shown         <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                shift_q    <= score;
                last_score <= score;
                bcd_q      <= '0;
                cnt        <= '0;
                sat_q      <= longint'(score) > MAX_SHOWN;
            end else if (state == CONV) begin
                shift_q <= shift_q << 1;
                bcd_q   <= bcd_step;
                cnt     <= cnt + 1'b1;
            end
            if (done) begin
                pending       <= result;
                pending_valid <= 1'b1;
            end
            // A frame boundary on the completing cycle takes the fresh result directly.
            if (frame_start) begin
                if (done)
                    shown <= result;
                else if (pending_valid)
                    shown <= pending;
                pending_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        int         u, v;
        logic [3:0] dig;
        logic [6:0] s;
        logic       draw;
`ifdef LEADING_ZERO_BLANK_EN
        logic       leading;
        leading = 1'b1;
`endif
        hit = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            dig  = shown[4*(NDIG-1-k) +: 4];
            draw = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if (leading && dig == 4'd0 && k != NDIG - 1)
                draw = 1'b0;
            else
                leading = 1'b0;
`endif
            u = int'(x) - (X0 + k * PITCH);
            v = int'(y) - Y0;
            s = seg_map(dig);
            if (draw && u >= 0 && u < DIG_W && v >= 0 && v < DIG_H)
                hit = hit
                    | (s[6] & (v < SEG_T))
                    | (s[5] & (u >= DIG_W - SEG_T) & (v <= DIG_H / 2))
                    | (s[4] & (u >= DIG_W - SEG_T) & (v >= DIG_H / 2))
                    | (s[3] & (v >= DIG_H - SEG_T))
                    | (s[2] & (u < SEG_T) & (v >= DIG_H / 2))
                    | (s[1] & (u < SEG_T) & (v <= DIG_H / 2))
                    | (s[0] & (v >= SEG_M) & (v < SEG_M + SEG_T));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_score  <= 1'b0;
            score_rgb <= '0;
        end else begin
            is_score  <= hit;
            score_rgb <= hit ? COLOR : 12'h000;
        end
    end

endmodule
